// File: rtl/config_loader_pkg.sv
// Shared types, header field layout and header validation for the configuration loader.
package config_loader_pkg;

    localparam int CM_DEPTH = 32;
    localparam int CM_WIDTH = 64;

    localparam logic [3:0] HDR_MAGIC = 4'hC;
    localparam int HDR_MAGIC_MSB = 63;
    localparam int HDR_MAGIC_LSB = 60;
    localparam int HDR_PE_MSB    = 7;
    localparam int HDR_PE_LSB    = 0;
    localparam int HDR_ADDR_MSB  = 12;
    localparam int HDR_ADDR_LSB  = 8;
    localparam int HDR_CNT_MSB   = 18;
    localparam int HDR_CNT_LSB   = 13;
    localparam int HDR_CNT_BITS  = HDR_CNT_MSB - HDR_CNT_LSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } cfg_ld_state_e;

    typedef enum logic [1:0] {
        HDR_OK,
        HDR_BAD_MAGIC,
        HDR_BAD_RANGE
    } hdr_status_e;

    // Range is checked on the full 8-bit id and on start+count without truncation,
    // so an accepted frame never runs past the last memory word.
    function automatic hdr_status_e hdr_ok(input logic [63:0] hdr,
                                           input int unsigned num_pe,
                                           input int unsigned depth);
        int unsigned pe;
        int unsigned start;
        int unsigned cnt;
        pe    = 32'(hdr[HDR_PE_MSB:HDR_PE_LSB]);
        start = 32'(hdr[HDR_ADDR_MSB:HDR_ADDR_LSB]);
        cnt   = 32'(hdr[HDR_CNT_MSB:HDR_CNT_LSB]);
        if (hdr[HDR_MAGIC_MSB:HDR_MAGIC_LSB] != HDR_MAGIC) begin
            return HDR_BAD_MAGIC;
        end
        if ((pe >= num_pe) || ((start + cnt) > depth)) begin
            return HDR_BAD_RANGE;
        end
        return HDR_OK;
    endfunction

endpackage

// File: rtl/config_loader_if.sv
// Valid/ready stream carrying header and body words from the host loader.
interface config_loader_if
    import config_loader_pkg::*;
#(
    parameter int DW = CM_WIDTH
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/config_loader.sv
// Parses header-framed configuration streams and issues registered writes
// into the selected PE's configuration memory.
module config_loader
    import config_loader_pkg::*;
#(
    parameter int NUM_PE       = 16,
    parameter int PE_ID_BITS   = $clog2(NUM_PE),
    parameter int CM_DEPTH     = config_loader_pkg::CM_DEPTH,
    parameter int CM_ADDR_BITS = 5,
    parameter int CM_WIDTH     = config_loader_pkg::CM_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_exec,
    config_loader_if.slave          in_if,
    output logic [NUM_PE-1:0]       pe_sel,
    output logic [CM_ADDR_BITS-1:0] control_mem_addr,
    output logic [CM_WIDTH-1:0]     control_mem_data_in,
    output logic [CM_WIDTH-1:0]     control_mem_bit_en,
    output logic                    control_mem_wr_en,
    output logic                    control_mem_en,
    output logic                    busy,
    output logic                    load_done,
    output logic                    load_err
);

    localparam logic [NUM_PE-1:0] PE_ONE = {{(NUM_PE-1){1'b0}}, 1'b1};

    cfg_ld_state_e             state_q, state_d;
    logic [CM_ADDR_BITS-1:0]   addr_q, addr_d;
    logic [HDR_CNT_BITS-1:0]   rem_q, rem_d;
    logic [NUM_PE-1:0]         sel_q, sel_d;
    logic                      ready_en_q, ready_en_d;
    logic                      wr_en_q, wr_en_d;
    logic [NUM_PE-1:0]         pe_sel_q, pe_sel_d;
    logic [CM_ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
    logic [CM_WIDTH-1:0]       wr_data_q, wr_data_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic                      accept;
    hdr_status_e               hdr_st;
    logic [HDR_CNT_BITS-1:0]   hdr_cnt;
    logic [PE_ID_BITS-1:0]     hdr_pe;

    // ready_en_q keeps in_ready low until the first clock after reset releases.
    assign in_if.in_ready = ready_en_q && !start_exec && (state_q != ST_DONE);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign hdr_st         = hdr_ok(in_if.in_data, NUM_PE, CM_DEPTH);
    assign hdr_cnt        = in_if.in_data[HDR_CNT_MSB:HDR_CNT_LSB];
    assign hdr_pe         = in_if.in_data[PE_ID_BITS-1:0];

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        sel_d      = sel_q;
        ready_en_d = 1'b1;
        wr_en_d    = 1'b0;
        pe_sel_d   = '0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (hdr_st)
                        HDR_BAD_MAGIC: err_d = 1'b1;
                        HDR_BAD_RANGE: begin
                            err_d = 1'b1;
                            if (hdr_cnt != '0) begin
                                rem_d   = hdr_cnt;
                                state_d = ST_DRAIN;
                            end
                        end
                        default: begin
                            if (hdr_cnt == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                addr_d  = in_if.in_data[HDR_ADDR_MSB:HDR_ADDR_LSB];
                                rem_d   = hdr_cnt;
                                sel_d   = PE_ONE << hdr_pe;
                                state_d = ST_WRITE;
                            end
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    pe_sel_d  = sel_q;
                    wr_addr_d = addr_q;
                    wr_data_d = in_if.in_data;
                    addr_d    = addr_q + 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == HDR_CNT_BITS'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == HDR_CNT_BITS'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE: begin
                if (!start_exec) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            sel_q      <= '0;
            ready_en_q <= 1'b0;
            wr_en_q    <= 1'b0;
            pe_sel_q   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            sel_q      <= sel_d;
            ready_en_q <= ready_en_d;
            wr_en_q    <= wr_en_d;
            pe_sel_q   <= pe_sel_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign pe_sel              = pe_sel_q;
    assign control_mem_addr    = wr_addr_q;
    assign control_mem_data_in = wr_data_q;
    assign control_mem_bit_en  = {CM_WIDTH{wr_en_q}};
    assign control_mem_wr_en   = wr_en_q;
    assign control_mem_en      = wr_en_q;
    assign busy                = (state_q != ST_IDLE);
    assign load_done           = done_q;
    assign load_err            = err_q;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: hand-computed expectations checked with
// immediate assertions one clock step at a time.
module tb_config_loader;

    logic        clk;
    logic        reset;
    logic        start_exec;
    logic [15:0] pe_sel;
    logic [4:0]  mem_addr;
    logic [63:0] mem_data;
    logic [63:0] mem_bit_en;
    logic        mem_wr_en;
    logic        mem_en;
    logic        busy;
    logic        load_done;
    logic        load_err;

    int vectors;
    int miscompares;

    config_loader_if #(.DW(64)) bus ();

    config_loader #(
        .NUM_PE      (16),
        .CM_DEPTH    (32),
        .CM_ADDR_BITS(5),
        .CM_WIDTH    (64)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start_exec         (start_exec),
        .in_if              (bus),
        .pe_sel             (pe_sel),
        .control_mem_addr   (mem_addr),
        .control_mem_data_in(mem_data),
        .control_mem_bit_en (mem_bit_en),
        .control_mem_wr_en  (mem_wr_en),
        .control_mem_en     (mem_en),
        .busy               (busy),
        .load_done          (load_done),
        .load_err           (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] hdr(input logic [3:0] magic, input logic [7:0] pe,
                                        input logic [4:0] addr, input logic [5:0] cnt);
        logic [63:0] h;
        h = '0;
        h[63:60] = magic;
        h[7:0]   = pe;
        h[12:8]  = addr;
        h[18:13] = cnt;
        return h;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
    endtask

    task automatic idle_bus();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic check_write(input string tag, input logic [4:0] a,
                               input logic [63:0] d, input logic [15:0] sel);
        chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd1);
        chk({tag, "_en"}, 64'(mem_en), 64'd1);
        chk({tag, "_bit_en"}, mem_bit_en, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
        chk({tag, "_data"}, mem_data, d);
        chk({tag, "_pe_sel"}, 64'(pe_sel), 64'(sel));
    endtask

    task automatic check_nowrite(input string tag);
        chk({tag, "_wr_en"}, 64'(mem_wr_en), 64'd0);
        chk({tag, "_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_bit_en"}, mem_bit_en, 64'd0);
        chk({tag, "_pe_sel"}, 64'(pe_sel), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start_exec  = 1'b0;
        idle_bus();
        #2 reset = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", mem_data, 64'd0);
        check_nowrite("rst");
        reset = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Frame 1: pe=3 addr=4 count=3, back-to-back body
        send(hdr(4'hC, 8'd3, 5'd4, 6'd3));
        chk("f1_busy", 64'(busy), 64'd1);
        check_nowrite("f1_hdr");
        send(64'hAAAA_0000_1111_2222);
        check_write("f1_w0", 5'd4, 64'hAAAA_0000_1111_2222, 16'h0008);
        send(64'hBBBB_3333_4444_5555);
        check_write("f1_w1", 5'd5, 64'hBBBB_3333_4444_5555, 16'h0008);
        send(64'hCCCC_6666_7777_8888);
        check_write("f1_w2", 5'd6, 64'hCCCC_6666_7777_8888, 16'h0008);
        chk("f1_done_early", 64'(load_done), 64'd0);
        chk("f1_ready_in_done", 64'(bus.in_ready), 64'd0);
        idle_bus();
        tick();
        chk("f1_done", 64'(load_done), 64'd1);
        check_nowrite("f1_after");
        chk("f1_busy_end", 64'(busy), 64'd0);
        tick();
        chk("f1_done_pulse", 64'(load_done), 64'd0);

        // Bad magic, then a normal single-word frame
        send(hdr(4'h5, 8'd3, 5'd4, 6'd3));
        chk("mag_err", 64'(load_err), 64'd1);
        chk("mag_busy", 64'(busy), 64'd0);
        check_nowrite("mag");
        idle_bus();
        tick();
        chk("mag_err_pulse", 64'(load_err), 64'd0);
        send(hdr(4'hC, 8'd0, 5'd0, 6'd1));
        send(64'h0123_4567_89AB_CDEF);
        check_write("mag_next", 5'd0, 64'h0123_4567_89AB_CDEF, 16'h0001);
        idle_bus();
        tick();
        chk("mag_next_done", 64'(load_done), 64'd1);

        // Out of range addr=30 count=3: drained without writes
        send(hdr(4'hC, 8'd1, 5'd30, 6'd3));
        chk("rng_err", 64'(load_err), 64'd1);
        chk("rng_busy", 64'(busy), 64'd1);
        send(64'h1);
        check_nowrite("rng_d0");
        chk("rng_err_pulse", 64'(load_err), 64'd0);
        send(64'h2);
        check_nowrite("rng_d1");
        send(64'h3);
        check_nowrite("rng_d2");
        chk("rng_busy_end", 64'(busy), 64'd0);
        send(hdr(4'hC, 8'd2, 5'd10, 6'd1));
        chk("rng_next_hdr_err", 64'(load_err), 64'd0);
        chk("rng_next_busy", 64'(busy), 64'd1);
        send(64'hEEEE_EEEE_0000_0001);
        check_write("rng_next", 5'd10, 64'hEEEE_EEEE_0000_0001, 16'h0004);
        idle_bus();
        tick();
        chk("rng_next_done", 64'(load_done), 64'd1);

        // pe_id 16 is out of range; count 0 keeps the loader in IDLE
        send(hdr(4'hC, 8'd16, 5'd0, 6'd0));
        chk("pe16_err", 64'(load_err), 64'd1);
        chk("pe16_busy", 64'(busy), 64'd0);
        // Last address of the last PE is legal
        send(hdr(4'hC, 8'd15, 5'd31, 6'd1));
        chk("edge_err", 64'(load_err), 64'd0);
        send(64'hFEED_FACE_DEAD_BEEF);
        check_write("edge", 5'd31, 64'hFEED_FACE_DEAD_BEEF, 16'h8000);
        idle_bus();
        tick();
        chk("edge_done", 64'(load_done), 64'd1);

        // start_exec stall after 2 of 5 words
        send(hdr(4'hC, 8'd5, 5'd8, 6'd5));
        send(64'h50);
        check_write("stl_w0", 5'd8, 64'h50, 16'h0020);
        send(64'h51);
        check_write("stl_w1", 5'd9, 64'h51, 16'h0020);
        start_exec   = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h52;
        #1;
        chk("stl_ready", 64'(bus.in_ready), 64'd0);
        tick();
        check_nowrite("stl_hold0");
        tick();
        check_nowrite("stl_hold1");
        chk("stl_busy", 64'(busy), 64'd1);
        start_exec = 1'b0;
        send(64'h52);
        check_write("stl_w2", 5'd10, 64'h52, 16'h0020);
        send(64'h53);
        check_write("stl_w3", 5'd11, 64'h53, 16'h0020);
        send(64'h54);
        check_write("stl_w4", 5'd12, 64'h54, 16'h0020);
        idle_bus();
        tick();
        chk("stl_done", 64'(load_done), 64'd1);

        // count=0: load_done two cycles after acceptance
        send(hdr(4'hC, 8'd7, 5'd3, 6'd0));
        chk("c0_done_early", 64'(load_done), 64'd0);
        chk("c0_busy", 64'(busy), 64'd1);
        check_nowrite("c0");
        idle_bus();
        tick();
        chk("c0_done", 64'(load_done), 64'd1);
        check_nowrite("c0_after");

        // Asynchronous reset mid-WRITE
        send(hdr(4'hC, 8'd4, 5'd0, 6'd4));
        send(64'h99);
        check_write("ar_w0", 5'd0, 64'h99, 16'h0010);
        reset = 1'b1;
        #1;
        check_nowrite("ar");
        chk("ar_ready", 64'(bus.in_ready), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_data", mem_data, 64'd0);
        tick();
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = hdr(4'hC, 8'd6, 5'd2, 6'd1);
        tick();
        chk("ar_rel_ready", 64'(bus.in_ready), 64'd1);
        chk("ar_rel_busy", 64'(busy), 64'd0);
        send(hdr(4'hC, 8'd6, 5'd2, 6'd1));
        chk("ar_hdr_busy", 64'(busy), 64'd1);
        check_nowrite("ar_hdr");
        send(64'h7777_0000_0000_0002);
        check_write("ar_new", 5'd2, 64'h7777_0000_0000_0002, 16'h0040);
        idle_bus();
        tick();
        chk("ar_new_done", 64'(load_done), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
